// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: arbitrates, launches operands, waits LAT cycles, returns result.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first) instead of round-robin.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DATA1_0,
    input  logic [WIDTH-1:0] DATA2_0,
    input  logic [2:0]       SELECT_0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DATA1_1,
    input  logic [WIDTH-1:0] DATA2_1,
    input  logic [2:0]       SELECT_1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic [WIDTH-1:0] RESULT_OUT,
    output logic             ZERO_OUT,
    output logic             BUSY,
    output logic [WIDTH-1:0] ALU_DATA1,
    output logic [WIDTH-1:0] ALU_DATA2,
    output logic [2:0]       ALU_SELECT,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_ZERO
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       port;     // port currently holding the ALU
    logic       win;      // arbitration winner if a launch happens this edge
    logic       launch;
    logic       capture;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win = ~REQ0;
`else
    logic last_served;
    // Contention goes to whichever port was not served last; a lone requester always wins.
    assign win = (REQ0 && REQ1) ? ~last_served : REQ1;
`endif

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        launch    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    launch    = 1'b1;
                    cnt_nxt   = 4'(LAT);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            GNT0       <= 1'b0;
            GNT1       <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            RESULT_OUT <= '0;
            ZERO_OUT   <= 1'b0;
            ALU_DATA1  <= '0;
            ALU_DATA2  <= '0;
            ALU_SELECT <= 3'b000;
            port       <= 1'b0;
        end else begin
            GNT0  <= launch & ~win;
            GNT1  <= launch & win;
            DONE0 <= capture & ~port;
            DONE1 <= capture & port;
            if (launch) begin
                port       <= win;
                ALU_DATA1  <= win ? DATA1_1  : DATA1_0;
                ALU_DATA2  <= win ? DATA2_1  : DATA2_0;
                ALU_SELECT <= win ? SELECT_1 : SELECT_0;
            end
            if (capture) begin
                RESULT_OUT <= ALU_RESULT;
                ZERO_OUT   <= ALU_ZERO;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset value 1 hands the first tie to port 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)       last_served <= 1'b1;
        else if (capture) last_served <= port;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a transaction-level timing model (grant at E, done at E+LAT).
module tb_alu_arbiter;
    localparam int W   = 8;
    localparam int LAT = 2;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         REQ0 = 1'b0, REQ1 = 1'b0;
    logic [W-1:0] DATA1_0 = '0, DATA2_0 = '0, DATA1_1 = '0, DATA2_1 = '0;
    logic [2:0]   SELECT_0 = '0, SELECT_1 = '0;
    logic         GNT0, GNT1, DONE0, DONE1, ZERO_OUT, BUSY, ALU_ZERO;
    logic [W-1:0] RESULT_OUT, ALU_DATA1, ALU_DATA2, ALU_RESULT;
    logic [2:0]   ALU_SELECT;

    int total = 0, bad = 0;

    alu_arbiter #(.WIDTH(W), .LAT(LAT)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .DATA1_0(DATA1_0), .DATA2_0(DATA2_0), .SELECT_0(SELECT_0),
        .REQ1(REQ1), .DATA1_1(DATA1_1), .DATA2_1(DATA2_1), .SELECT_1(SELECT_1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RESULT_OUT(RESULT_OUT), .ZERO_OUT(ZERO_OUT), .BUSY(BUSY),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
        .ALU_RESULT(ALU_RESULT), .ALU_ZERO(ALU_ZERO)
    );

    always #5 CLK = ~CLK;

    // External ALU: {zero, result}
    function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
        logic [W-1:0] r;
        case (s)
            3'b000:  r = a;
            3'b001:  r = a + b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            default: r = '0;
        endcase
        return {(s == 3'b001) && (r == '0), r};
    endfunction

    assign {ALU_ZERO, ALU_RESULT} = alu_fn(ALU_DATA1, ALU_DATA2, ALU_SELECT);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int         cyc = 0;
    int         grant_cyc = -1, done_cyc = -1, free_at = 0;
    bit         m_last = 1'b1, m_port = 1'b0;
    logic [W-1:0] m_res = '0, m_d1 = '0, m_d2 = '0, p_res = '0;
    logic [2:0] m_sel = '0;
    bit         m_zero = 1'b0, p_zero = 1'b0;
    int         glog[$];
    logic [W:0] rlog[$];

    task automatic model_reset();
        grant_cyc = -1; done_cyc = -1; free_at = 0;
        m_last = 1'b1; m_port = 1'b0;
        m_res = '0; m_zero = 1'b0;
        m_d1 = '0; m_d2 = '0; m_sel = '0;
    endtask

    task automatic step();
        bit eg0, eg1, ed0, ed1, eb;
        logic [W:0] zr;
        @(posedge CLK);
        cyc++;
        eg0 = 0; eg1 = 0; ed0 = 0; ed1 = 0;
        if (!RESET) model_reset();
        else if (cyc == done_cyc) begin
            ed0 = !m_port; ed1 = m_port;
            m_res = p_res; m_zero = p_zero; m_last = m_port;
        end else if (cyc >= free_at && (REQ0 || REQ1)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            m_port = !REQ0;
`else
            m_port = (REQ0 && REQ1) ? !m_last : REQ1;
`endif
            m_d1  = m_port ? DATA1_1  : DATA1_0;
            m_d2  = m_port ? DATA2_1  : DATA2_0;
            m_sel = m_port ? SELECT_1 : SELECT_0;
            zr = alu_fn(m_d1, m_d2, m_sel);
            p_res = zr[W-1:0]; p_zero = zr[W];
            grant_cyc = cyc; done_cyc = cyc + LAT; free_at = cyc + LAT + 1;
            eg0 = !m_port; eg1 = m_port;
        end
        eb = RESET && (cyc >= grant_cyc) && (cyc < done_cyc);
        #1;
        chk("gnt0", GNT0, eg0);
        chk("gnt1", GNT1, eg1);
        chk("done0", DONE0, ed0);
        chk("done1", DONE1, ed1);
        chk("result", RESULT_OUT, m_res);
        chk("zero", ZERO_OUT, m_zero);
        chk("busy", BUSY, eb);
        chk("alu_ops", {ALU_SELECT, ALU_DATA2, ALU_DATA1}, {m_sel, m_d2, m_d1});
        if (GNT0) glog.push_back(0);
        if (GNT1) glog.push_back(1);
        if (DONE0 || DONE1) rlog.push_back({ZERO_OUT, RESULT_OUT});
    endtask

    // Runs n cycles; a port not told to hold drops REQ once its grant is seen.
    task automatic run(input int n, input bit hold0, input bit hold1);
        for (int i = 0; i < n; i++) begin
            step();
            if (GNT0 && !hold0) REQ0 = 1'b0;
            if (GNT1 && !hold1) REQ1 = 1'b0;
        end
    endtask

    task automatic do_reset();
        REQ0 = 0; REQ1 = 0;
        RESET = 1'b0;
        #1 model_reset();
        step(); step();
        RESET = 1'b1;
    endtask

    task automatic rand_ops(output logic [W-1:0] d1, output logic [W-1:0] d2, output logic [2:0] s);
        s  = 3'($urandom_range(0, 7));
        d1 = W'($urandom);
        d2 = ($urandom_range(0, 3) == 0) ? W'(-d1) : W'($urandom);
    endtask

    task automatic rand_port(inout logic req, inout logic [W-1:0] d1, inout logic [W-1:0] d2,
                             inout logic [2:0] s, input logic gnt);
        if (req && gnt) begin
            if ($urandom_range(0, 1) == 0) req = 1'b0;
            else rand_ops(d1, d2, s);
        end else if (!req) begin
            if ($urandom_range(0, 2) == 0) begin
                req = 1'b1;
                rand_ops(d1, d2, s);
            end
        end else if ($urandom_range(0, 19) == 0) begin
            req = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", BUSY, 0);
        chk("rst_result", RESULT_OUT, 0);
        step(); step();
        RESET = 1'b1;

        // ADD 0x05 + 0xFB wraps to zero
        REQ0 = 1; DATA1_0 = 8'h05; DATA2_0 = 8'hFB; SELECT_0 = 3'b001;
        run(4, 0, 0);
        chk("add_zero_res", RESULT_OUT, 8'h00);
        chk("add_zero_flag", ZERO_OUT, 1);

        // Simultaneous first requests after reset: port 0 first
        do_reset();
        glog.delete(); rlog.delete();
        REQ0 = 1; DATA1_0 = 8'h0F; DATA2_0 = 8'hF0; SELECT_0 = 3'b011;
        REQ1 = 1; DATA1_1 = 8'hFF; DATA2_1 = 8'h3C; SELECT_1 = 3'b010;
        run(8, 0, 0);
        chk("tie_cnt", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("tie_g0", glog[0], 0);
            chk("tie_g1", glog[1], 1);
        end
        chk("tie_rcnt", rlog.size(), 2);
        if (rlog.size() == 2) begin
            chk("tie_r0", rlog[0], {1'b0, 8'hFF});
            chk("tie_r1", rlog[1], {1'b0, 8'h3C});
        end

        // Both held for 6 operations
        glog.delete();
        REQ0 = 1; DATA1_0 = 8'h01; DATA2_0 = 8'h01; SELECT_0 = 3'b001;
        REQ1 = 1; DATA1_1 = 8'h33; DATA2_1 = 8'h00; SELECT_1 = 3'b000;
        run(6 * (LAT + 1), 1, 1);
        REQ0 = 0; REQ1 = 0;
        run(LAT + 1, 0, 0);
        chk("rr_cnt", glog.size(), 6);
        for (int i = 0; i < glog.size() && i < 6; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("rr_order", glog[i], 0);
`else
            chk("rr_order", glog[i], i % 2);
`endif
        end

        // Out-of-range SELECT, then ADD 1+1
        REQ1 = 1; DATA1_1 = 8'hAA; DATA2_1 = 8'h55; SELECT_1 = 3'b101;
        run(4, 0, 0);
        chk("sel101_res", RESULT_OUT, 8'h00);
        chk("sel101_zero", ZERO_OUT, 0);
        REQ0 = 1; DATA1_0 = 8'h01; DATA2_0 = 8'h01; SELECT_0 = 3'b001;
        run(4, 0, 0);
        chk("add11_res", RESULT_OUT, 8'h02);
        chk("add11_zero", ZERO_OUT, 0);

        // Reset one cycle after GNT1 abandons the op
        REQ1 = 1; DATA1_1 = 8'hFF; DATA2_1 = 8'h3C; SELECT_1 = 3'b010;
        begin
            bit seen = 0;
            for (int i = 0; i < 8 && !seen; i++) begin
                step();
                if (GNT1) begin seen = 1; REQ1 = 0; end
            end
            chk("rst_wait_gnt1", seen, 1);
        end
        step();
        #2 RESET = 1'b0;
        #1;
        chk("async_busy", BUSY, 0);
        chk("async_result", RESULT_OUT, 8'h00);
        model_reset();
        step(); step(); step();
        RESET = 1'b1;
        glog.delete();
        REQ0 = 1; DATA1_0 = 8'h12; DATA2_0 = 8'h34; SELECT_0 = 3'b011;
        run(4, 0, 0);
        chk("post_rst_cnt", glog.size(), 1);
        if (glog.size() > 0) chk("post_rst_port", glog[0], 0);

`ifdef ALU_ARB_FIXED_PRIO_EN
        glog.delete();
        REQ0 = 1; REQ1 = 1;
        run(4 * (LAT + 1), 1, 1);
        chk("fp_cnt", glog.size(), 4);
        foreach (glog[i]) chk("fp_port", glog[i], 0);
        REQ0 = 0;
        glog.delete();
        run(LAT + 1, 0, 0);
        chk("fp_p1_cnt", glog.size(), 1);
        if (glog.size() > 0) chk("fp_p1", glog[0], 1);
        REQ1 = 0;
        run(LAT + 1, 0, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step();
            rand_port(REQ0, DATA1_0, DATA2_0, SELECT_0, GNT0);
            rand_port(REQ1, DATA1_1, DATA2_1, SELECT_1, GNT1);
        end
        REQ0 = 0; REQ1 = 0;
        run(LAT + 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
